// File: rtl/key_cmd_pkg.sv
// +----------------------------------------------------------------------+
// | key_cmd_pkg: repeat FSM encodings and key timing constants.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package key_cmd_pkg;

   localparam logic [1:0] IDLE_ENC   = 2'd0;
   localparam logic [1:0] HOLD_ENC   = 2'd1;
   localparam logic [1:0] REPEAT_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = IDLE_ENC,
      ST_HOLD   = HOLD_ENC,
      ST_REPEAT = REPEAT_ENC
   } rep_state_e;

   // Board-scale defaults and the shortened values used in simulation
   localparam int HOLD_CYCLES_DEF    = 500;
   localparam int REPEAT_CYCLES_DEF  = 200;
   localparam int HOLD_CYCLES_TEST   = 8;
   localparam int REPEAT_CYCLES_TEST = 4;

   function automatic int kw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cntw_f(input int h, input int r);
      int m;
      m = (h > r) ? h : r;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_cmd_if.sv
// +----------------------------------------------------------------------+
// | key_cmd_if: valid/ready move-command channel.                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface key_cmd_if #(
   parameter int N = 4
);
   import key_cmd_pkg::*;

   localparam int KW = kw_f(N);

   logic          cmd_valid;
   logic          cmd_ready;
   logic [KW-1:0] cmd_key;
   logic          cmd_repeat;

   modport master (
      output cmd_valid,
      output cmd_key,
      output cmd_repeat,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_key,
      input  cmd_repeat,
      output cmd_ready
   );

endinterface

`default_nettype wire

// File: rtl/key_prio_enc.sv
// +----------------------------------------------------------------------+
// | key_prio_enc: lowest-index priority encoder with any/multi flags.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module key_prio_enc
   import key_cmd_pkg::*;
#(
   parameter int N  = 4,
   parameter int KW = kw_f(N)
) (
   input  logic [N-1:0]  req_i,
   output logic [KW-1:0] idx_o,
   output logic          any_o,
   output logic          multi_o
);

   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = KW'(i);
         end
      end
   end

   assign any_o   = |req_i;
   // Clearing the lowest set bit leaves something only if two or more were set
   assign multi_o = |(req_i & (req_i - N'(1)));

endmodule

`default_nettype wire

// File: rtl/key_cmd.sv
// +----------------------------------------------------------------------+
// | key_cmd: key press to move-command converter, optional typematic     |
// | repeat when built with KEY_REPEAT_EN.                 Rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module key_cmd
   import key_cmd_pkg::*;
#(
   parameter int N             = 4,
   parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic [N-1:0]  key_in_i,
   key_cmd_if.master     cmd_if,
   output logic          cmd_ovf_o,
   output logic [N-1:0]  key_held_o
);

   localparam int KW = kw_f(N);

   if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_chk
      $error("key_cmd: HOLD_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
   end

   logic [N-1:0]  key_q;
   logic          valid_q, valid_d;
   logic [KW-1:0] ckey_q, ckey_d;
   logic          rep_q, rep_d;
   logic          ovf_q, ovf_d;

   logic [N-1:0]  w_press;
   logic [KW-1:0] w_idx;
   logic          w_any;
   logic          w_multi;
   logic          w_can_load;
   logic          w_press_load;
   logic          w_rep_emit;
   logic [KW-1:0] w_owner;

   assign w_press      = key_q & ~key_in_i;
   assign w_can_load   = ~valid_q | cmd_if.cmd_ready;
   assign w_press_load = w_any & w_can_load;

   key_prio_enc #(
      .N  (N),
      .KW (KW)
   ) u_prio (
      .req_i   (w_press),
      .idx_o   (w_idx),
      .any_o   (w_any),
      .multi_o (w_multi)
   );

`ifdef KEY_REPEAT_EN
   localparam int            CW          = cntw_f(HOLD_CYCLES, REPEAT_CYCLES);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

   rep_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] owner_q, owner_d;
   logic          w_released;

   assign w_released = key_in_i[owner_q];
   assign w_owner    = owner_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      w_rep_emit = 1'b0;
      case (state_q)
         ST_HOLD: begin
            if (w_released) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               w_rep_emit = 1'b1;
               cnt_d      = '0;
               state_d    = ST_REPEAT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_REPEAT: begin
            if (w_released) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == REPEAT_LAST) begin
               w_rep_emit = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
      // An accepted press re-arms the timer from any state
      if (w_press_load) begin
         owner_d = w_idx;
         cnt_d   = '0;
         state_d = ST_HOLD;
      end
   end
`else
   assign w_rep_emit = 1'b0;
   assign w_owner    = '0;
`endif

   always_comb begin
      valid_d = valid_q;
      ckey_d  = ckey_q;
      rep_d   = rep_q;
      ovf_d   = w_multi | (w_any & ~w_can_load);
      if (w_press_load) begin
         valid_d = 1'b1;
         ckey_d  = w_idx;
         rep_d   = 1'b0;
      end else if (w_rep_emit & w_can_load) begin
         valid_d = 1'b1;
         ckey_d  = w_owner;
         rep_d   = 1'b1;
      end else if (valid_q & cmd_if.cmd_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         key_q   <= '1;
         valid_q <= 1'b0;
         ckey_q  <= '0;
         rep_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         key_q   <= key_in_i;
         valid_q <= valid_d;
         ckey_q  <= ckey_d;
         rep_q   <= rep_d;
         ovf_q   <= ovf_d;
      end
   end

   assign cmd_if.cmd_valid  = valid_q;
   assign cmd_if.cmd_key    = ckey_q;
   assign cmd_if.cmd_repeat = rep_q;
   assign cmd_ovf_o         = ovf_q;
   assign key_held_o        = ~key_q;

endmodule

`default_nettype wire

// File: tb/tb_key_cmd.sv
// +----------------------------------------------------------------------+
// | tb_key_cmd: self-checking bench for key_cmd against a cycle model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_key_cmd;
   import key_cmd_pkg::*;

   localparam int N = 4;
   localparam int H = HOLD_CYCLES_TEST;
   localparam int R = REPEAT_CYCLES_TEST;

   logic       clk  = 1'b0;
   logic       nrst = 1'b1;
   logic [3:0] key_in = 4'hF;
   logic       cmd_ovf;
   logic [3:0] key_held;

   key_cmd_if #(.N(N)) cmd_if ();

   key_cmd #(
      .N             (N),
      .HOLD_CYCLES   (H),
      .REPEAT_CYCLES (R)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .key_in_i   (key_in),
      .cmd_if     (cmd_if),
      .cmd_ovf_o  (cmd_ovf),
      .key_held_o (key_held)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference: tracks previous key levels, the pending command and the
   // time elapsed since the owning key's press command was accepted.
   typedef struct packed {
      logic        valid;
      logic [1:0]  key;
      logic        rep;
      logic        ovf;
      logic [3:0]  prev;
      logic        active;
      logic [1:0]  owner;
      logic [15:0] elapsed;
   } mdl_t;

   localparam mdl_t MDL_RST = '{valid: 1'b0, key: 2'd0, rep: 1'b0, ovf: 1'b0,
                                prev: 4'hF, active: 1'b0, owner: 2'd0, elapsed: 16'd0};

   function automatic mdl_t model_step(input mdl_t s, input logic [3:0] kin, input logic rdy);
      mdl_t       n;
      logic [3:0] press;
      bit         can;
      bit         take;
      bit         due;
      int         lo;
`ifdef KEY_REPEAT_EN
      int         e;
`endif
      n     = s;
      press = s.prev & ~kin;
      can   = !s.valid || rdy;
      take  = (press != 4'd0) && can;
      due   = 1'b0;
      lo    = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (press[i]) lo = i;
      end
      n.prev = kin;
      n.ovf  = ((press != 4'd0) && !can) || ($countones(press) > 1);
`ifdef KEY_REPEAT_EN
      if (s.active && !take) begin
         if (kin[s.owner]) begin
            n.active  = 1'b0;
            n.elapsed = 16'd0;
         end else begin
            e         = int'(s.elapsed) + 1;
            n.elapsed = 16'(e);
            due       = (e >= H) && (((e - H) % R) == 0);
         end
      end
`endif
      if (take) begin
         n.valid = 1'b1;
         n.key   = 2'(lo);
         n.rep   = 1'b0;
`ifdef KEY_REPEAT_EN
         n.active  = 1'b1;
         n.owner   = 2'(lo);
         n.elapsed = 16'd0;
`endif
      end else if (due && can) begin
         n.valid = 1'b1;
         n.key   = s.owner;
         n.rep   = 1'b1;
      end else if (s.valid && rdy) begin
         n.valid = 1'b0;
      end
      return n;
   endfunction

   mdl_t m;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) m <= MDL_RST;
      else       m <= model_step(m, key_in, cmd_if.cmd_ready);
   end

   logic [8:0] dut_v;
   logic [8:0] mdl_v;
   assign dut_v = {cmd_if.cmd_valid, cmd_if.cmd_key, cmd_if.cmd_repeat, cmd_ovf, key_held};
   assign mdl_v = {m.valid, m.key, m.rep, m.ovf, ~m.prev};

   task automatic test_reset();
      key_in           = 4'hF;
      cmd_if.cmd_ready = 1'b0;
      #1 nrst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (dut_v !== 9'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=%b", dut_v, 9'd0);
      end
      nrst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (cmd_if.cmd_valid !== 1'b0 || dut_v !== mdl_v) begin
            failures++;
            $display("FAIL reset_idle cycle=%0d got=%b want=%b", c, dut_v, mdl_v);
         end
      end
   endtask

   task automatic test_single_press();
      key_in           = 4'b1011;
      cmd_if.cmd_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_if.cmd_valid, cmd_if.cmd_key, cmd_if.cmd_repeat, cmd_ovf} !== 5'b1_10_0_0) begin
         failures++;
         $display("FAIL single_press got v=%b k=%0d r=%b o=%b want v=1 k=2 r=0 o=0",
                  cmd_if.cmd_valid, cmd_if.cmd_key, cmd_if.cmd_repeat, cmd_ovf);
      end
      @(negedge clk);
      checks++;
      if (cmd_if.cmd_valid !== 1'b0 || dut_v !== mdl_v) begin
         failures++;
         $display("FAIL single_handshake got=%b want=%b", dut_v, mdl_v);
      end
      key_in = 4'hF;
      @(negedge clk);
   endtask

   task automatic test_multi_press();
      key_in           = 4'b0101;
      cmd_if.cmd_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_key !== 2'd1 || cmd_ovf !== 1'b1) begin
         failures++;
         $display("FAIL multi_press got v=%b k=%0d o=%b want v=1 k=1 o=1",
                  cmd_if.cmd_valid, cmd_if.cmd_key, cmd_ovf);
      end
      @(negedge clk);
      checks++;
      if (cmd_ovf !== 1'b0 || cmd_if.cmd_valid !== 1'b0) begin
         failures++;
         $display("FAIL multi_ovf_pulse got v=%b o=%b want v=0 o=0", cmd_if.cmd_valid, cmd_ovf);
      end
      key_in = 4'hF;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      key_in           = 4'b1110;
      cmd_if.cmd_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_key !== 2'd0 || cmd_ovf !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d got v=%b k=%0d o=%b want v=1 k=0 o=0",
                     c, cmd_if.cmd_valid, cmd_if.cmd_key, cmd_ovf);
         end
      end
      key_in = 4'b1010;
      @(negedge clk);
      checks++;
      if (cmd_ovf !== 1'b1 || cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_key !== 2'd0) begin
         failures++;
         $display("FAIL bp_drop got v=%b k=%0d o=%b want v=1 k=0 o=1",
                  cmd_if.cmd_valid, cmd_if.cmd_key, cmd_ovf);
      end
      key_in = 4'hF;
      @(negedge clk);
      checks++;
      if (cmd_ovf !== 1'b0 || cmd_if.cmd_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_ovf_once got v=%b o=%b want v=1 o=0", cmd_if.cmd_valid, cmd_ovf);
      end
      cmd_if.cmd_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_if.cmd_valid !== 1'b0 || dut_v !== mdl_v) begin
         failures++;
         $display("FAIL bp_release got=%b want=%b", dut_v, mdl_v);
      end
   endtask

   task automatic test_back_to_back();
      cmd_if.cmd_ready = 1'b1;
      key_in           = 4'b1110;
      @(negedge clk);
      key_in = 4'b1100;
      @(negedge clk);
      checks++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_key !== 2'd1 || cmd_ovf !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second got v=%b k=%0d o=%b want v=1 k=1 o=0",
                  cmd_if.cmd_valid, cmd_if.cmd_key, cmd_ovf);
      end
      key_in = 4'hF;
      @(negedge clk);
      checks++;
      if (cmd_if.cmd_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain got v=%b want v=0", cmd_if.cmd_valid);
      end
   endtask

   task automatic test_reset_mid();
      cmd_if.cmd_ready = 1'b0;
      key_in           = 4'b1101;
      @(negedge clk);
      #2 nrst = 1'b0;
      @(negedge clk);
      checks++;
      if (dut_v !== 9'd0) begin
         failures++;
         $display("FAIL mid_reset got=%b want=%b", dut_v, 9'd0);
      end
      nrst = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_key !== 2'd1 || cmd_if.cmd_repeat !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_repress got v=%b k=%0d r=%b want v=1 k=1 r=0",
                  cmd_if.cmd_valid, cmd_if.cmd_key, cmd_if.cmd_repeat);
      end
      key_in           = 4'hF;
      cmd_if.cmd_ready = 1'b1;
      @(negedge clk);
   endtask

`ifdef KEY_REPEAT_EN
   task automatic test_repeat();
      bit exp_v;
      cmd_if.cmd_ready = 1'b1;
      key_in           = 4'b0111;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         exp_v = (j == 0) || (j == H) || (j == H + R) || (j == H + 2 * R);
         checks++;
         if (cmd_if.cmd_valid !== exp_v ||
             (exp_v && (cmd_if.cmd_key !== 2'd3 || cmd_if.cmd_repeat !== (j != 0))) ||
             dut_v !== mdl_v) begin
            failures++;
            $display("FAIL repeat j=%0d got v=%b k=%0d r=%b want v=%b k=3 r=%b",
                     j, cmd_if.cmd_valid, cmd_if.cmd_key, cmd_if.cmd_repeat, exp_v, j != 0);
         end
         if (j == 17) key_in = 4'hF;
      end
   endtask
`else
   task automatic test_no_repeat();
      cmd_if.cmd_ready = 1'b1;
      key_in           = 4'b0111;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         checks++;
         if (cmd_if.cmd_valid !== (j == 0) || cmd_if.cmd_repeat !== 1'b0 ||
             (j == 0 && cmd_if.cmd_key !== 2'd3)) begin
            failures++;
            $display("FAIL no_repeat j=%0d got v=%b k=%0d r=%b want v=%b k=3 r=0",
                     j, cmd_if.cmd_valid, cmd_if.cmd_key, cmd_if.cmd_repeat, j == 0);
         end
         if (j == 17) key_in = 4'hF;
      end
   endtask
`endif

   task automatic test_random();
      int k;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            k         = int'($urandom_range(0, 3));
            key_in[k] = ~key_in[k];
         end
         if ($urandom_range(0, 31) == 0) key_in = 4'($urandom);
         cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         checks++;
         if (dut_v !== mdl_v) begin
            failures++;
            $display("FAIL random cycle=%0d got={v,k,r,o,held}=%b want=%b", c, dut_v, mdl_v);
         end
      end
      key_in = 4'hF;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_multi_press();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef KEY_REPEAT_EN
      test_repeat();
`else
      test_no_repeat();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
